// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, states,
// datapath select codes and the opcode class latched during decode.
package mips_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    typedef logic [3:0] state_t;
    localparam state_t StIdle     = 4'd0;
    localparam state_t StFetch    = 4'd1;
    localparam state_t StDecode   = 4'd2;
    localparam state_t StMemAddr  = 4'd3;
    localparam state_t StMemRead  = 4'd4;
    localparam state_t StMemWb    = 4'd5;
    localparam state_t StMemWrite = 4'd6;
    localparam state_t StRExec    = 4'd7;
    localparam state_t StRWb      = 4'd8;
    localparam state_t StImmExec  = 4'd9;
    localparam state_t StImmWb    = 4'd10;
    localparam state_t StBranch   = 4'd11;
    localparam state_t StJump     = 4'd12;
    localparam state_t StJal      = 4'd13;
    localparam state_t StFault    = 4'd14;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluFunct = 3'b010;
    localparam logic [2:0] AluLui   = 3'b011;
    localparam logic [2:0] AluOr    = 3'b100;

    localparam logic [1:0] AluBReg    = 2'b00;
    localparam logic [1:0] AluBFour   = 2'b01;
    localparam logic [1:0] AluBImm    = 2'b10;
    localparam logic [1:0] AluBBranch = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [1:0] MemToRegAlu = 2'b00;
    localparam logic [1:0] MemToRegMem = 2'b01;
    localparam logic [1:0] MemToRegPc  = 2'b10;

    typedef enum logic [2:0] {ClsNone, ClsLw, ClsSw, ClsAddi, ClsOri, ClsLui} opclass_t;

    function automatic opclass_t opclass_of(input logic [5:0] op);
        case (op)
            OpLw:    return ClsLw;
            OpSw:    return ClsSw;
            OpAddi:  return ClsAddi;
            OpOri:   return ClsOri;
            OpLui:   return ClsLui;
            default: return ClsNone;
        endcase
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the instruction register / memory handshake and the
// multi-cycle datapath. master = control unit, slave = datapath side.
interface multicycle_control_if #(
    parameter int unsigned ALUOP_W = 3
);
    logic [31:0]        instr;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_done;
    logic               fault;

    modport master (
        input  instr, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
               alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_source, alu_op, instr_done, fault
    );

    modport slave (
        output instr, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
               alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_source, alu_op, instr_done, fault
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags a timeout when a memory state has waited
// TIMEOUT-1 cycles and still sees no ready in the current one.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active && !mem_ready) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // A ready in the limit cycle completes the access rather than faulting.
    assign expired = active && !mem_ready && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives the shared-datapath selects from the state register.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ALUOP_W = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);
    state_t     state_q, state_d;
    opclass_t   cls_q, cls_d;
    logic [5:0] opcode;
    logic [2:0] aop;
    logic       timer_clear, timer_active, timer_expired;

    assign opcode       = bus.instr[31:26];
    assign timer_active = is_mem_state(state_q);
    assign timer_clear  = (state_d != state_q) && is_mem_state(state_d);

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .active   (timer_active),
        .mem_ready(bus.mem_ready),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (bus.mem_ready)      state_d = StDecode;
                else if (timer_expired) state_d = StFault;
            end
            StDecode: begin
                cls_d = opclass_of(opcode);
                case (opcode)
                    OpRtype:              state_d = StRExec;
                    OpLw, OpSw:           state_d = StMemAddr;
                    OpBeq:                state_d = StBranch;
                    OpJ:                  state_d = StJump;
                    OpJal:                state_d = StJal;
                    OpAddi, OpOri, OpLui: state_d = StImmExec;
                    default:              state_d = StFault;
                endcase
            end
            StMemAddr: state_d = (cls_q == ClsSw) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (bus.mem_ready)      state_d = StMemWb;
                else if (timer_expired) state_d = StFault;
            end
            StMemWrite: begin
                if (bus.mem_ready)      state_d = StFetch;
                else if (timer_expired) state_d = StFault;
            end
            StRExec:   state_d = StRWb;
            StImmExec: state_d = StImmWb;
            StMemWb, StRWb, StImmWb, StBranch, StJump, StJal: state_d = StFetch;
            StFault:   state_d = StFault;
            default:   state_d = StFault;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.reg_dst       = RegDstRt;
        bus.mem_to_reg    = MemToRegAlu;
        bus.alu_src_b     = AluBReg;
        bus.pc_source     = PcSrcAlu;
        bus.instr_done    = 1'b0;
        bus.fault         = 1'b0;
        aop               = AluAdd;
        case (state_q)
            StFetch: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = AluBFour;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            StDecode:  bus.alu_src_b = AluBBranch;
            StMemAddr: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = AluBImm;
            end
            StMemRead: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = MemToRegMem;
                bus.instr_done = 1'b1;
            end
            StMemWrite: begin
                bus.mem_write  = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            StRExec: begin
                bus.alu_src_a = 1'b1;
                aop           = AluFunct;
            end
            StRWb, StImmWb: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = (state_q == StRWb) ? RegDstRd : RegDstRt;
                bus.instr_done = 1'b1;
            end
            StImmExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = AluBImm;
                aop = (cls_q == ClsOri) ? AluOr : (cls_q == ClsLui) ? AluLui : AluAdd;
            end
            StBranch: begin
                bus.alu_src_a     = 1'b1;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PcSrcAluOut;
                bus.instr_done    = 1'b1;
                aop               = AluSub;
            end
            StJump, StJal: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PcSrcJump;
                bus.instr_done = 1'b1;
                if (state_q == StJal) begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = RegDstRa;
                    bus.mem_to_reg = MemToRegPc;
                end
            end
            StFault: bus.fault = 1'b1;
            default: ;
        endcase
        bus.alu_op = ALUOP_W'(aop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cls_q   <= ClsNone;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction expected
// cycle counts and write-back controls are compared at each instr_done pulse.
module tb_multicycle_control;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if #(.ALUOP_W(3)) bus ();

    multicycle_control #(
        .TIMEOUT(TO),
        .ALUOP_W(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cycles;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       pw;
        logic       pwc;
        logic [1:0] psrc;
        logic       mw;
        logic       has_alu;
        logic [2:0] aop;
        logic [1:0] asb;
    } rec_t;

    rec_t expq[$];
    logic rdyq[$];
    rec_t act;
    rec_t exp_r;
    int   mcyc = 0;
    bit   seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [20:0] outs();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.alu_src_a, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src_b, bus.pc_source, bus.alu_op, bus.instr_done, bus.fault};
    endfunction

    // Instruction-level model: total latency and the completing cycle's controls.
    function automatic rec_t model(input logic [5:0] op, input int wf, input int wm,
                                   input bit idle);
        rec_t r;
        int   base;
        r = '0;
        base = 0;
        case (op)
            6'h23: begin base = 5 + wm; r.rw = 1; r.m2r = 2'b01; r.has_alu = 1;
                         r.aop = 3'b000; r.asb = 2'b10; end
            6'h2B: begin base = 4 + wm; r.mw = 1; r.has_alu = 1;
                         r.aop = 3'b000; r.asb = 2'b10; end
            6'h00: begin base = 4; r.rw = 1; r.rd = 2'b01; r.has_alu = 1;
                         r.aop = 3'b010; r.asb = 2'b00; end
            6'h08: begin base = 4; r.rw = 1; r.has_alu = 1; r.aop = 3'b000; r.asb = 2'b10; end
            6'h0D: begin base = 4; r.rw = 1; r.has_alu = 1; r.aop = 3'b100; r.asb = 2'b10; end
            6'h0F: begin base = 4; r.rw = 1; r.has_alu = 1; r.aop = 3'b011; r.asb = 2'b10; end
            6'h04: begin base = 3; r.pwc = 1; r.psrc = 2'b01; r.has_alu = 1;
                         r.aop = 3'b001; r.asb = 2'b00; end
            6'h02: begin base = 3; r.pw = 1; r.psrc = 2'b10; end
            6'h03: begin base = 3; r.pw = 1; r.psrc = 2'b10; r.rw = 1;
                         r.rd = 2'b10; r.m2r = 2'b10; end
            default: base = 0;
        endcase
        r.cycles = 8'(base + wf + (idle ? 1 : 0));
        return r;
    endfunction

    // Per-cycle mem_ready plan; non-memory cycles get random values.
    task automatic plan(input logic [5:0] op, input int wf, input int wm, input bit idle);
        if (idle) rdyq.push_back(1'($urandom));
        repeat (wf) rdyq.push_back(1'b0);
        rdyq.push_back(1'b1);
        rdyq.push_back(1'($urandom));
        case (op)
            6'h23: begin
                rdyq.push_back(1'($urandom));
                repeat (wm) rdyq.push_back(1'b0);
                rdyq.push_back(1'b1);
                rdyq.push_back(1'($urandom));
            end
            6'h2B: begin
                rdyq.push_back(1'($urandom));
                repeat (wm) rdyq.push_back(1'b0);
                rdyq.push_back(1'b1);
            end
            6'h00, 6'h08, 6'h0D, 6'h0F: begin
                rdyq.push_back(1'($urandom));
                rdyq.push_back(1'($urandom));
            end
            default: rdyq.push_back(1'($urandom));
        endcase
    endtask

    task automatic drive(input logic [31:0] ins);
        bus.instr = ins;
        while (rdyq.size() > 0) begin
            bus.mem_ready = rdyq.pop_front();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input bit idle);
        expq.push_back(model(op, wf, wm, idle));
        plan(op, wf, wm, idle);
        drive({op, 26'($urandom)});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mcyc = 0;
            seen = 0;
        end else begin
            mcyc++;
            if (!seen && bus.alu_src_a) begin
                seen    = 1;
                act.aop = bus.alu_op;
                act.asb = bus.alu_src_b;
            end
            if (bus.instr_done) begin
                act.cycles  = 8'(mcyc);
                act.rw      = bus.reg_write;
                act.rd      = bus.reg_dst;
                act.m2r     = bus.mem_to_reg;
                act.pw      = bus.pc_write;
                act.pwc     = bus.pc_write_cond;
                act.psrc    = bus.pc_source;
                act.mw      = bus.mem_write;
                act.has_alu = seen;
                if (!seen) begin
                    act.aop = '0;
                    act.asb = '0;
                end
                if (expq.size() == 0) begin
                    check("unexpected_done", 32'(act), 32'hFFFF_FFFF);
                end else begin
                    exp_r = expq.pop_front();
                    check("instr_record", 32'(act), 32'(exp_r));
                end
                mcyc = 0;
                seen = 0;
            end
        end
    end

    logic [5:0] ops [11];
    logic [5:0] op;
    int wf, wm;

    initial begin
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        bus.instr     = '0;
        bus.mem_ready = 1'b0;
        #2;
        check("reset_outputs", 32'(outs()), 32'h0);
        do_reset();
        check("idle_outputs", 32'(outs()), 32'h0);

        run_instr(6'h23, 0, 0, 1);   // lw 0x8C010004
        run_instr(6'h0F, 0, 0, 0);   // lui
        run_instr(6'h03, 0, 0, 0);   // jal
        run_instr(6'h2B, 0, TO - 1, 0);
        check("no_fault_ready_at_limit", 32'(bus.fault), 32'h0);
        run_instr(6'h23, TO - 1, TO - 1, 0);

        for (int i = 0; i < 150; i++) begin
            op = ops[$urandom_range(0, 10)];
            wf = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, TO - 1);
            wm = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, TO - 1);
            run_instr(op, wf, wm, 0);
        end
        check("queue_drained", 32'(expq.size()), 32'h0);

        // Illegal opcode: fault is sticky with all other outputs low.
        do_reset();
        rdyq.push_back(1'b1);
        rdyq.push_back(1'b1);
        rdyq.push_back(1'b1);
        drive(32'hFC00_0000);
        for (int i = 0; i < 20; i++) begin
            check("illegal_fault_sticky", 32'(outs()), 32'h1);
            bus.mem_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("fault_cleared_by_reset", 32'(outs()), 32'h0);

        // sw store timeout.
        do_reset();
        rdyq.push_back(1'b0);
        rdyq.push_back(1'b1);
        rdyq.push_back(1'b1);
        rdyq.push_back(1'b1);
        repeat (TO) rdyq.push_back(1'b0);
        drive(32'hAC01_0004);
        check("store_timeout_fault", 32'(outs()), 32'h1);

        // Fetch timeout.
        do_reset();
        rdyq.push_back(1'b1);
        repeat (TO) rdyq.push_back(1'b0);
        drive(32'h0000_0020);
        check("fetch_timeout_fault", 32'(outs()), 32'h1);

        // Asynchronous reset in the middle of a store.
        do_reset();
        rdyq.push_back(1'b0);
        rdyq.push_back(1'b1);
        rdyq.push_back(1'b0);
        rdyq.push_back(1'b0);
        drive(32'hAC01_0008);
        bus.mem_ready = 1'b0;
        #1;
        check("in_mem_write", 32'(bus.mem_write), 32'h1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_mem_write", 32'(outs()), 32'h0);

        do_reset();
        run_instr(6'h23, 1, 2, 1);
        run_instr(6'h04, 0, 0, 0);
        check("final_queue_drained", 32'(expq.size()), 32'h0);
        check("final_no_fault", 32'(bus.fault), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back over 3–5+ cycles. It drives the shared-datapath muxes and enables, stalls on a memory ready handshake, and flags illegal opcodes and memory timeouts. It sits between the instruction register and the multi-cycle datapath, in place of single-cycle opcode decoding.

## Interface
- `TIMEOUT`, default 16: maximum cycles a memory state waits for `mem_ready` before faulting; legal range ≥2.
- `ALUOP_W`, default 3: width of `alu_op`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction register contents; only `instr[31:26]` is decoded, and only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `iord`, `mem_read`, `mem_write`, `ir_write`, `reg_write`, `alu_src_a` out 1 each.
- `reg_dst`, `mem_to_reg`, `alu_src_b`, `pc_source` out 2 each.
- `alu_op` out ALUOP_W: 000 add, 001 sub, 010 funct, 011 lui, 100 or.
- `instr_done` out 1: pulses on the final cycle of each instruction.
- `fault` out 1: sticky; illegal opcode or memory timeout.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, IMM_EXEC, IMM_WB, BRANCH, JUMP, JAL, FAULT.
- All outputs are a pure function of the state register. `ir_write` and `pc_write` in FETCH also depend on `mem_ready`. Any output not listed for a state is 0.
- IDLE: all outputs 0 → FETCH next cycle.
- FETCH:
  - Always: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=add, `pc_source`=00.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1; → DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=add (precomputes the branch target). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 / 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - 001000 / 001101 / 001111 → IMM_EXEC
  - any other → FAULT
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=add → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: `mem_read`=1, `iord`=1; waits for `mem_ready` → MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01, `instr_done`=1 → FETCH.
- MEM_WRITE: `mem_write`=1, `iord`=1; waits for `mem_ready`, then `instr_done`=1 → FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=funct → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00, `instr_done`=1 → FETCH.
- IMM_EXEC: `alu_src_a`=1, `alu_src_b`=10; `alu_op` = add (addi), or (ori), lui (lui), using the opcode latched in DECODE → IMM_WB.
- IMM_WB: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00, `instr_done`=1 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=sub, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1 → FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1 → FETCH.
- JAL: same as JUMP, plus `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10.
- FAULT: `fault`=1, all other outputs 0; absorbing until `rst_n` is asserted.
- Wait counter, width $clog2(TIMEOUT+1):
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle in those states while `mem_ready`=0.
  - If it reaches TIMEOUT−1 with `mem_ready`=0 → FAULT.
- A 3-bit opcode class register is latched in DECODE; it feeds IMM_EXEC `alu_op` and the MEM_ADDR branch.

## Timing
- Reset: the asynchronous assert forces state=IDLE, wait counter=0 and class=0, so every output is 0, including `fault`. Deassert is sampled on the next rising edge. A reset mid-instruction abandons it with no partial write enables.
- Cycle counts with zero-wait memory (`mem_ready`=1 on the first cycle):
  - lw: 5
  - sw, R-type, imm: 4
  - beq, j, jal: 3
- Each memory wait cycle adds 1.
- `mem_ready` sampled high in the same cycle the counter hits the limit: completion wins, no fault.
- `mem_ready` is ignored in every non-memory state.
- `instr_done` is high for exactly one cycle per instruction.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode constants
  - state enum
  - `alu_op` encodings
  - `alu_src_b`, `pc_source`, `reg_dst` and `mem_to_reg` select encodings
  - opcode-class enum
- Sub-module `mem_wait_timer` (parameter TIMEOUT):
  - inputs: `clear`, `active`, `mem_ready`
  - output: `expired`
- The FSM and output decode stay in `multicycle_control`.

## Test plan
- Reset, then instr=0x8C010004 (lw) with `mem_ready` held at 1 → IDLE, then 5 states; `instr_done` in cycle 6; `reg_write`=1 with `mem_to_reg`=01 in MEM_WB.
- instr=0x3C01ABCD (lui), `mem_ready`=1 → `alu_op`=011, `alu_src_b`=10 in IMM_EXEC; `reg_write` in IMM_WB; 4 cycles total.
- instr=0x0C000010 (jal) → JAL asserts `pc_write`=1, `pc_source`=10, `reg_dst`=10, `mem_to_reg`=10, `reg_write`=1 in one cycle.
- Opcode 0x3F in DECODE → FAULT next cycle; `fault` stays 1 for 20 cycles; `rst_n` low clears it.
- TIMEOUT=4, sw with `mem_ready`=0 for 4 cycles → FAULT. Repeat with `mem_ready`=1 on the 4th cycle → FETCH, no fault.
- `rst_n` pulsed low during MEM_WRITE → `mem_write` drops immediately; state IDLE.
